// File: rtl/alu_sequencer.sv
// alu_sequencer: execute-stage controller sitting in front of a 4-bit ALU.
// Accepts one decoded op per handshake, reads operands from a small register
// file, drives the ALU for one cycle, then writes back the result and flags.
// Every op takes three cycles: IDLE -> EXEC -> WB.
// Optional build macro ALU_SEQ_ILLEGAL_TRAP_EN adds a sticky illegal_op output
// that halts the sequencer after an illegal function code.
module alu_sequencer #(
   parameter int NREG   = 4,
   parameter int REG_AW = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [2:0]        op_sel,
   input  logic [REG_AW-1:0] op_dst,
   input  logic [REG_AW-1:0] op_src,
   input  logic [3:0]        op_imm,
   input  logic              op_use_imm,
   input  logic [1:0]        op_cin_mode,
   output logic [3:0]        alu_a,
   output logic [3:0]        alu_b,
   output logic [2:0]        alu_sel,
   output logic              alu_cin,
   input  logic [3:0]        alu_out,
   input  logic              alu_cout,
   output logic              wb_valid,
   output logic [REG_AW-1:0] wb_dst,
   output logic [3:0]        wb_data,
   output logic              carry_flag,
   output logic              zero_flag,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [3:0]        dbg_data
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
   ,
   output logic              illegal_op
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   state_t              state_r;
   logic [3:0]          regs_r [NREG];
   logic [REG_AW-1:0]   dst_r;
   logic                legal_r;
   logic [3:0]          result_r;
   logic                cout_r;
   logic                op_ready_r;
   logic [3:0]          alu_a_r;
   logic [3:0]          alu_b_r;
   logic [2:0]          alu_sel_r;
   logic                alu_cin_r;
   logic                wb_valid_r;
   logic [REG_AW-1:0]   wb_dst_r;
   logic [3:0]          wb_data_r;
   logic                carry_flag_r;
   logic                zero_flag_r;
   logic                accept_s;
   logic                halt_s;
   logic [3:0]          b_operand_s;
   logic                cin_s;

   // Function codes 000 and 001 have no ALU meaning.
   function automatic logic sel_is_legal(input logic [2:0] sel);
      return sel[2] | sel[1];
   endfunction

   // Carry-in selection; mode 11 is reserved and behaves as a zero carry-in.
   function automatic logic cin_select(input logic [1:0] mode, input logic flag);
      logic cin;
      case (mode)
         2'b00:   cin = 1'b0;
         2'b01:   cin = 1'b1;
         2'b10:   cin = flag;
         default: cin = 1'b0;
      endcase
      return cin;
   endfunction

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
   logic illegal_op_r;
   assign illegal_op = illegal_op_r;
   assign halt_s     = illegal_op_r;
`else
   assign halt_s     = 1'b0;
`endif

   assign accept_s   = op_valid & op_ready_r;
   assign op_ready   = op_ready_r;
   assign alu_a      = alu_a_r;
   assign alu_b      = alu_b_r;
   assign alu_sel    = alu_sel_r;
   assign alu_cin    = alu_cin_r;
   assign wb_valid   = wb_valid_r;
   assign wb_dst     = wb_dst_r;
   assign wb_data    = wb_data_r;
   assign carry_flag = carry_flag_r;
   assign zero_flag  = zero_flag_r;
   assign dbg_data   = regs_r[dbg_addr];

   // Operand B and carry-in as they will be presented to the ALU in EXEC.
   always_comb begin
      b_operand_s = 4'd0;
      cin_s       = 1'b0;
      if (op_use_imm) begin
         b_operand_s = op_imm;
      end else begin
         b_operand_s = regs_r[op_src];
      end
      cin_s = cin_select(op_cin_mode, carry_flag_r);
   end

   // Sequencer FSM: op capture, ALU drive, result capture and write-back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= 4'd0;
         end
         dst_r        <= '0;
         legal_r      <= 1'b0;
         result_r     <= 4'd0;
         cout_r       <= 1'b0;
         op_ready_r   <= 1'b1;
         alu_a_r      <= 4'd0;
         alu_b_r      <= 4'd0;
         alu_sel_r    <= 3'b111;
         alu_cin_r    <= 1'b0;
         wb_valid_r   <= 1'b0;
         wb_dst_r     <= '0;
         wb_data_r    <= 4'd0;
         carry_flag_r <= 1'b0;
         zero_flag_r  <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
         illegal_op_r <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               wb_valid_r <= 1'b0;
               if (accept_s) begin
                  // Registers cannot change before EXEC, so operands are
                  // registered here and presented unchanged during EXEC.
                  dst_r      <= op_dst;
                  legal_r    <= sel_is_legal(op_sel);
                  alu_a_r    <= regs_r[op_dst];
                  alu_b_r    <= b_operand_s;
                  alu_sel_r  <= sel_is_legal(op_sel) ? op_sel : 3'b111;
                  alu_cin_r  <= cin_s;
                  op_ready_r <= 1'b0;
                  state_r    <= ST_EXEC;
               end else begin
                  op_ready_r <= ~halt_s;
                  state_r    <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               result_r  <= alu_out;
               cout_r    <= alu_cout;
               alu_a_r   <= 4'd0;
               alu_b_r   <= 4'd0;
               alu_sel_r <= 3'b111;
               alu_cin_r <= 1'b0;
               if (legal_r) begin
                  wb_valid_r <= 1'b1;
                  wb_dst_r   <= dst_r;
                  wb_data_r  <= alu_out;
               end else begin
                  wb_valid_r <= 1'b0;
               end
               state_r <= ST_WB;
            end
            ST_WB: begin
               wb_valid_r <= 1'b0;
               if (legal_r) begin
                  regs_r[dst_r] <= result_r;
                  carry_flag_r  <= cout_r;
                  zero_flag_r   <= (result_r == 4'd0);
                  op_ready_r    <= 1'b1;
               end else begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                  illegal_op_r  <= 1'b1;
                  op_ready_r    <= 1'b0;
`else
                  op_ready_r    <= 1'b1;
`endif
               end
               state_r <= ST_IDLE;
            end
            default: begin
               wb_valid_r <= 1'b0;
               op_ready_r <= ~halt_s;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: behavioural 4-bit ALU attached to the ALU port,
// table of directed ops with hand-computed results, plus sequences for
// back-to-back throughput, illegal function codes and reset in mid-op.
module tb_alu_sequencer;

   logic       clk;
   logic       rst_n;
   logic       op_valid;
   logic       op_ready;
   logic [2:0] op_sel;
   logic [1:0] op_dst;
   logic [1:0] op_src;
   logic [3:0] op_imm;
   logic       op_use_imm;
   logic [1:0] op_cin_mode;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_sel;
   logic       alu_cin;
   logic [3:0] alu_out;
   logic       alu_cout;
   logic       wb_valid;
   logic [1:0] wb_dst;
   logic [3:0] wb_data;
   logic       carry_flag;
   logic       zero_flag;
   logic [1:0] dbg_addr;
   logic [3:0] dbg_data;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
   logic       illegal_op;
`endif

   int n_checks = 0;
   int n_errors = 0;

   alu_sequencer #(.NREG(4), .REG_AW(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_sel(op_sel), .op_dst(op_dst), .op_src(op_src), .op_imm(op_imm),
      .op_use_imm(op_use_imm), .op_cin_mode(op_cin_mode),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
      .alu_out(alu_out), .alu_cout(alu_cout),
      .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
      .carry_flag(carry_flag), .zero_flag(zero_flag),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      , .illegal_op(illegal_op)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model of the downstream 4-bit ALU.
   always_comb begin
      logic [4:0] s;
      s = 5'd0;
      case (alu_sel)
         3'b010:  s = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_cin};
         3'b011:  s = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
         3'b100:  s = {1'b0, alu_a ^ alu_b} + {4'd0, alu_cin};
         3'b101:  s = {1'b0, alu_a | alu_b} + {4'd0, alu_cin};
         3'b110:  s = {1'b0, alu_a & alu_b} + {4'd0, alu_cin};
         default: s = {1'b0, alu_a} + {4'd0, alu_cin};
      endcase
      alu_out  = s[3:0];
      alu_cout = s[4];
   end

   typedef struct {
      logic [2:0] sel;
      logic [1:0] dst;
      logic [1:0] src;
      logic [3:0] imm;
      logic       use_imm;
      logic [1:0] cin_mode;
      logic [3:0] exp_a;
      logic [3:0] exp_b;
      logic [2:0] exp_sel;
      logic       exp_cin;
      logic       exp_wbv;
      logic [3:0] exp_reg;
      logic       exp_c;
      logic       exp_z;
   } vec_t;

   vec_t vecs [15];

   function automatic vec_t mk(input logic [2:0] sel, input logic [1:0] dst, input logic [1:0] src,
                               input logic [3:0] imm, input logic ui, input logic [1:0] cm,
                               input logic [3:0] a, input logic [3:0] b, input logic [2:0] s,
                               input logic ci, input logic wbv, input logic [3:0] r,
                               input logic c, input logic z);
      vec_t v;
      v.sel = sel; v.dst = dst; v.src = src; v.imm = imm; v.use_imm = ui; v.cin_mode = cm;
      v.exp_a = a; v.exp_b = b; v.exp_sel = s; v.exp_cin = ci;
      v.exp_wbv = wbv; v.exp_reg = r; v.exp_c = c; v.exp_z = z;
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!op_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!op_ready) chk("ready_timeout", 8'(op_ready), 8'd1);
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      logic exp_rdy;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      exp_rdy = v.exp_wbv;
`else
      exp_rdy = 1'b1;
`endif
      wait_ready();
      op_sel = v.sel; op_dst = v.dst; op_src = v.src; op_imm = v.imm;
      op_use_imm = v.use_imm; op_cin_mode = v.cin_mode; op_valid = 1'b1;
      @(posedge clk);
      #1 op_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_alu_a", idx),   8'(alu_a),   8'(v.exp_a));
      chk($sformatf("v%0d_alu_b", idx),   8'(alu_b),   8'(v.exp_b));
      chk($sformatf("v%0d_alu_sel", idx), 8'(alu_sel), 8'(v.exp_sel));
      chk($sformatf("v%0d_alu_cin", idx), 8'(alu_cin), 8'(v.exp_cin));
      chk($sformatf("v%0d_exec_ready", idx), 8'(op_ready), 8'd0);
      @(negedge clk);
      chk($sformatf("v%0d_wb_valid", idx), 8'(wb_valid), 8'(v.exp_wbv));
      if (v.exp_wbv) begin
         chk($sformatf("v%0d_wb_data", idx), 8'(wb_data), 8'(v.exp_reg));
         chk($sformatf("v%0d_wb_dst", idx),  8'(wb_dst),  8'(v.dst));
      end
      dbg_addr = v.dst;
      @(negedge clk);
      chk($sformatf("v%0d_carry", idx),   8'(carry_flag), 8'(v.exp_c));
      chk($sformatf("v%0d_zero", idx),    8'(zero_flag),  8'(v.exp_z));
      chk($sformatf("v%0d_reg", idx),     8'(dbg_data),   8'(v.exp_reg));
      chk($sformatf("v%0d_ready", idx),   8'(op_ready),   8'(exp_rdy));
      chk($sformatf("v%0d_wb_done", idx), 8'(wb_valid),   8'd0);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      chk($sformatf("v%0d_illegal", idx), 8'(illegal_op), 8'(!v.exp_wbv));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int wbcnt;
      vec_t tv;

      //          sel     dst   src   imm   ui    cm     a     b     sel    cin   wbv   reg   c     z
      vecs[0]  = mk(3'b101, 2'd1, 2'd0, 4'h3, 1'b1, 2'b00, 4'h0, 4'h3, 3'b101, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
      vecs[1]  = mk(3'b101, 2'd2, 2'd0, 4'h5, 1'b1, 2'b00, 4'h0, 4'h5, 3'b101, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
      vecs[2]  = mk(3'b011, 2'd1, 2'd2, 4'h0, 1'b0, 2'b00, 4'h3, 4'h5, 3'b011, 1'b0, 1'b1, 4'h8, 1'b0, 1'b0);
      vecs[3]  = mk(3'b110, 2'd1, 2'd0, 4'h0, 1'b1, 2'b00, 4'h8, 4'h0, 3'b110, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
      vecs[4]  = mk(3'b101, 2'd1, 2'd0, 4'h9, 1'b1, 2'b00, 4'h0, 4'h9, 3'b101, 1'b0, 1'b1, 4'h9, 1'b0, 1'b0);
      vecs[5]  = mk(3'b011, 2'd1, 2'd0, 4'h7, 1'b1, 2'b00, 4'h9, 4'h7, 3'b011, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1);
      vecs[6]  = mk(3'b110, 2'd1, 2'd0, 4'h0, 1'b1, 2'b00, 4'h0, 4'h0, 3'b110, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
      vecs[7]  = mk(3'b101, 2'd1, 2'd0, 4'h5, 1'b1, 2'b00, 4'h0, 4'h5, 3'b101, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
      vecs[8]  = mk(3'b101, 2'd3, 2'd0, 4'h2, 1'b1, 2'b00, 4'h0, 4'h2, 3'b101, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
      vecs[9]  = mk(3'b010, 2'd1, 2'd2, 4'h0, 1'b0, 2'b01, 4'h5, 4'h5, 3'b010, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1);
      vecs[10] = mk(3'b010, 2'd3, 2'd0, 4'h3, 1'b1, 2'b10, 4'h2, 4'h3, 3'b010, 1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
      vecs[11] = mk(3'b011, 2'd3, 2'd0, 4'h1, 1'b1, 2'b10, 4'hF, 4'h1, 3'b011, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1);
      vecs[12] = mk(3'b100, 2'd2, 2'd2, 4'h0, 1'b0, 2'b00, 4'h5, 4'h5, 3'b100, 1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
      vecs[13] = mk(3'b111, 2'd1, 2'd0, 4'h0, 1'b1, 2'b01, 4'h0, 4'h0, 3'b111, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0);
      vecs[14] = mk(3'b011, 2'd1, 2'd0, 4'hF, 1'b1, 2'b11, 4'h1, 4'hF, 3'b011, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1);

      rst_n = 1'b0; op_valid = 1'b0; op_sel = 3'b000; op_dst = 2'd0; op_src = 2'd0;
      op_imm = 4'h0; op_use_imm = 1'b0; op_cin_mode = 2'b00; dbg_addr = 2'd0;
      repeat (3) @(negedge clk);
      chk("rst_ready",   8'(op_ready),   8'd1);
      chk("rst_wbv",     8'(wb_valid),   8'd0);
      chk("rst_wbdata",  8'(wb_data),    8'd0);
      chk("rst_wbdst",   8'(wb_dst),     8'd0);
      chk("rst_carry",   8'(carry_flag), 8'd0);
      chk("rst_zero",    8'(zero_flag),  8'd0);
      chk("rst_alu_sel", 8'(alu_sel),    8'h7);
      chk("rst_alu_a",   8'(alu_a),      8'd0);
      chk("rst_alu_b",   8'(alu_b),      8'd0);
      chk("rst_reg0",    8'(dbg_data),   8'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         apply_vec(vecs[i], i);
      end

      // Held op_valid with three queued adds into r0: accepts at 0, 3, 6 only.
      wait_ready();
      op_sel = 3'b011; op_dst = 2'd0; op_src = 2'd0; op_use_imm = 1'b1;
      op_cin_mode = 2'b00; op_imm = 4'h1; op_valid = 1'b1; wbcnt = 0;
      for (int k = 0; k < 9; k++) begin
         if (k > 0) @(negedge clk);
         chk($sformatf("tp_ready_%0d", k), 8'(op_ready), 8'((k % 3) == 0));
         if (wb_valid) wbcnt++;
         if (k == 0) op_imm = 4'h1;
         if (k == 3) op_imm = 4'h2;
         if (k == 6) op_imm = 4'h4;
         if (k == 8) begin
            op_valid = 1'b0;
            dbg_addr = 2'd0;
         end
      end
      @(negedge clk);
      chk("tp_wb_count", 8'(wbcnt),      8'd3);
      chk("tp_r0",       8'(dbg_data),   8'h7);
      chk("tp_carry",    8'(carry_flag), 8'd0);
      chk("tp_ready_end", 8'(op_ready),  8'd1);

      // Illegal function code leaves r2 and flags untouched.
      tv = mk(3'b101, 2'd2, 2'd0, 4'h6, 1'b1, 2'b00, 4'h0, 4'h6, 3'b101, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0);
      apply_vec(tv, 100);
      tv = mk(3'b001, 2'd2, 2'd0, 4'hF, 1'b1, 2'b01, 4'h6, 4'hF, 3'b111, 1'b1, 1'b0, 4'h6, 1'b0, 1'b0);
      apply_vec(tv, 101);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      repeat (3) @(negedge clk);
      chk("trap_halt_ready", 8'(op_ready),   8'd0);
      chk("trap_sticky",     8'(illegal_op), 8'd1);
`endif

      // Reset asserted while an op is in EXEC aborts it.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tv = mk(3'b011, 2'd1, 2'd0, 4'hF, 1'b1, 2'b01, 4'h0, 4'hF, 3'b011, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1);
      apply_vec(tv, 200);
      wait_ready();
      op_sel = 3'b011; op_dst = 2'd1; op_imm = 4'h1; op_use_imm = 1'b1;
      op_cin_mode = 2'b00; op_valid = 1'b1;
      @(posedge clk);
      #1 op_valid = 1'b0;
      @(negedge clk);
      chk("rx_exec_b", 8'(alu_b), 8'h1);
      rst_n = 1'b0;
      #1;
      chk("rx_ready",   8'(op_ready),   8'd1);
      chk("rx_alu_sel", 8'(alu_sel),    8'h7);
      chk("rx_alu_b",   8'(alu_b),      8'd0);
      chk("rx_carry",   8'(carry_flag), 8'd0);
      chk("rx_zero",    8'(zero_flag),  8'd0);
      chk("rx_wbv",     8'(wb_valid),   8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dbg_addr = 2'd1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("rx_no_wb_%0d", k), 8'(wb_valid), 8'd0);
      end
      chk("rx_r1",       8'(dbg_data),   8'd0);
      chk("rx_ready_end", 8'(op_ready),  8'd1);
      chk("rx_carry_end", 8'(carry_flag), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
